ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 16, width of the ALU result, branch target and store data.
REQ-002 Parameter REG_W, default 3, destination register index width.
REQ-003 Parameter CNT_W, default 16, width of the stall and bubble counters.
REQ-004 Parameter ZERO_REG_FWD, default 0; when 0, register index 0 is never forwarded.
REQ-005 clk  in  1  stage clock.
REQ-006 rst  in  1  reset, active-high, synchronous.
REQ-007 hit_in  in  1  stage enable (cache hit); 0 = hold.
REQ-008 flush_in  in  1  replace the stage contents with a bubble.
REQ-009 valid_in  in  1  the incoming EX instruction is real.
REQ-010 alu_result_in, adder_result_in, regfile_read_data_2_in  in  DATA_W each  EX datapath values.
REQ-011 zero_in  in  1  ALU zero flag; mux_rd_rt_in  in  REG_W  destination register.
REQ-012 MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  control bits.
REQ-013 Registered "_out" copies of every REQ-010..012 field, plus valid_out  out  1.
REQ-014 pc_src_out  out  1  branch taken.
REQ-015 fwd_en_out  out  1, fwd_reg_out  out  REG_W, fwd_data_out  out  DATA_W  EX forwarding source.
REQ-016 stall_cnt_out, bubble_cnt_out  out  CNT_W each  performance counters.

Function
REQ-017 All state SHALL update on the falling edge of clk only, matching the other pipeline registers.
REQ-018 Edge priority SHALL be: rst, then flush_in, then hit_in=0 (hold), then load.
REQ-019 On a load edge, every _out field SHALL take its _in value one falling edge later, and valid_out SHALL take valid_in.
REQ-020 On a load edge with valid_in=0, the five control outputs SHALL be loaded as 0; datapath fields load normally.
REQ-021 On a flush edge, valid_out and all five control outputs SHALL become 0, datapath fields SHALL hold, and this SHALL happen regardless of hit_in.
REQ-022 On a hold edge, all _out fields and valid_out SHALL keep their values.
REQ-023 pc_src_out SHALL be combinational: valid_out AND Branch_out AND Zero_out.
REQ-024 fwd_en_out SHALL be combinational: valid_out AND RegWrite_out AND NOT MemRead_out AND (mux_rd_rt_out != 0 OR ZERO_REG_FWD=1).
REQ-025 fwd_reg_out SHALL equal mux_rd_rt_out, and fwd_data_out SHALL equal ALU_Result_out.
REQ-026 stall_cnt_out SHALL increment by 1 on every hold edge.
REQ-027 bubble_cnt_out SHALL increment by 1 on every flush edge, and on every load edge with valid_in=0.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 When flush_in and hit_in=0 coincide, only bubble_cnt_out SHALL increment.

Reset
REQ-030 When rst=1 at a falling edge, all _out fields, valid_out and both counters SHALL become 0, overriding flush_in and hit_in.
REQ-031 After reset, pc_src_out and fwd_en_out SHALL be 0.
REQ-032 A reset arriving during a hold SHALL discard the held instruction.
REQ-033 Outputs SHALL be undefined only before the first rst edge; no initial blocks SHALL be used.

Structure
REQ-034 Package mips_pkg SHALL hold the DATA_W and REG_W defaults and a typedef ctrl_t for the five control bits, shared with ID_EX and MEM_WB successors.
REQ-035 The counters SHALL use one sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice.

Verification
REQ-036 rst=1 for one edge, then load ALU=0x1234, rd=3, RegWrite=1, valid=1, hit=1 -> outputs 0 after reset; after one edge ALU_Result_out=0x1234, fwd_en_out=1, fwd_reg_out=3.
REQ-037 Load Branch=1, zero=1, valid=1 -> pc_src_out=1; repeat with valid_in=0 -> pc_src_out=0, Branch_out=0, bubble_cnt_out=1.
REQ-038 hit_in=0 for 5 edges with changing inputs -> outputs frozen, stall_cnt_out=5; hit_in=1 -> the new input is captured on the next edge.
REQ-039 flush_in=1 with hit_in=0 while MemWrite_out=1 -> MemWrite_out=0, valid_out=0, ALU_Result_out unchanged, bubble_cnt_out+1, stall_cnt_out unchanged.
REQ-040 CNT_W=3, 9 hold edges -> stall_cnt_out=7; rst, flush and hit=0 on the same edge -> all outputs 0.
REQ-041 Load rd=0 with RegWrite=1 -> fwd_en_out=0; load MemRead=1, rd=2 -> fwd_en_out=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: default datapath widths and the packed control-bit bundle
// carried from ID_EX through EX_MEM to MEM_WB.
package mips_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 3;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // A bubble must never write state, so its control bits are forced to the NOP pattern.
    function automatic ctrl_t ctrl_gate(input ctrl_t ctrl, input logic valid);
        return valid ? ctrl : CTRL_NOP;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, falling-edge clocked with synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(negedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flush/hold control, branch resolution, EX forwarding
// source and stall/bubble performance counters. State moves on the falling edge of clk.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int CNT_W        = 16,
    parameter bit ZERO_REG_FWD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit_in,
    input  logic              flush_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] adder_result_in,
    input  logic [DATA_W-1:0] regfile_read_data_2_in,
    input  logic              zero_in,
    input  logic [REG_W-1:0]  mux_rd_rt_in,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              Branch_in,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] adder_result_out,
    output logic [DATA_W-1:0] regfile_read_data_2_out,
    output logic              zero_out,
    output logic [REG_W-1:0]  mux_rd_rt_out,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic              MemRead_out,
    output logic              MemWrite_out,
    output logic              Branch_out,
    output logic              valid_out,
    output logic              pc_src_out,
    output logic              fwd_en_out,
    output logic [REG_W-1:0]  fwd_reg_out,
    output logic [DATA_W-1:0] fwd_data_out,
    output logic [CNT_W-1:0]  stall_cnt_out,
    output logic [CNT_W-1:0]  bubble_cnt_out
);

    ctrl_t             ctrl_in, ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] alu_q, alu_d, adder_q, adder_d, wdata_q, wdata_d;
    logic              zero_q, zero_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              stall_inc, bubble_inc;

    assign ctrl_in = '{mem_to_reg: MemToReg_in, reg_write: RegWrite_in, mem_read: MemRead_in,
                       mem_write: MemWrite_in, branch: Branch_in};

    // Flush wins over hold: it kills the instruction but leaves the datapath fields alone.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        adder_d = adder_q;
        wdata_d = wdata_q;
        zero_d  = zero_q;
        rd_d    = rd_q;
        if (flush_in) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (hit_in) begin
            valid_d = valid_in;
            ctrl_d  = ctrl_gate(ctrl_in, valid_in);
            alu_d   = alu_result_in;
            adder_d = adder_result_in;
            wdata_d = regfile_read_data_2_in;
            zero_d  = zero_in;
            rd_d    = mux_rd_rt_in;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            alu_q   <= '0;
            adder_q <= '0;
            wdata_q <= '0;
            zero_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            adder_q <= adder_d;
            wdata_q <= wdata_d;
            zero_q  <= zero_d;
            rd_q    <= rd_d;
        end
    end

    assign stall_inc  = !flush_in && !hit_in;
    assign bubble_inc = flush_in || (hit_in && !valid_in);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt_out)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_cnt_out)
    );

    assign alu_result_out          = alu_q;
    assign adder_result_out        = adder_q;
    assign regfile_read_data_2_out = wdata_q;
    assign zero_out                = zero_q;
    assign mux_rd_rt_out           = rd_q;
    assign MemToReg_out            = ctrl_q.mem_to_reg;
    assign RegWrite_out            = ctrl_q.reg_write;
    assign MemRead_out             = ctrl_q.mem_read;
    assign MemWrite_out            = ctrl_q.mem_write;
    assign Branch_out              = ctrl_q.branch;
    assign valid_out               = valid_q;

    assign pc_src_out   = valid_q && ctrl_q.branch && zero_q;
    // Loads are excluded: their value only exists after MEM, so EX forwarding would be stale.
    assign fwd_en_out   = valid_q && ctrl_q.reg_write && !ctrl_q.mem_read
                          && ((rd_q != '0) || ZERO_REG_FWD);
    assign fwd_reg_out  = rd_q;
    assign fwd_data_out = alu_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage against a behavioural stage model.
module tb_ex_mem_stage;

    localparam int DW = 16;
    localparam int RW = 3;
    localparam int BIG_CW = 16;
    localparam int SML_CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, hit_in, flush_in, valid_in, zero_in;
    logic [DW-1:0] alu_in, add_in, wd_in;
    logic [RW-1:0] rd_in;
    logic [4:0]    c_in;   // {MemToReg, RegWrite, MemRead, MemWrite, Branch}

    logic [DW-1:0] b_alu, b_add, b_wd, b_fdata, s_alu, s_add, s_wd, s_fdata;
    logic          b_zero, b_m2r, b_rw, b_mr, b_mw, b_br, b_valid, b_pc, b_fen;
    logic          s_zero, s_m2r, s_rw, s_mr, s_mw, s_br, s_valid, s_pc, s_fen;
    logic [RW-1:0] b_rd, b_freg, s_rd, s_freg;
    logic [BIG_CW-1:0] b_stall, b_bubble;
    logic [SML_CW-1:0] s_stall, s_bubble;

    ex_mem_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(BIG_CW)) dut_big (
        .clk(clk), .rst(rst), .hit_in(hit_in), .flush_in(flush_in), .valid_in(valid_in),
        .alu_result_in(alu_in), .adder_result_in(add_in), .regfile_read_data_2_in(wd_in),
        .zero_in(zero_in), .mux_rd_rt_in(rd_in),
        .MemToReg_in(c_in[4]), .RegWrite_in(c_in[3]), .MemRead_in(c_in[2]),
        .MemWrite_in(c_in[1]), .Branch_in(c_in[0]),
        .alu_result_out(b_alu), .adder_result_out(b_add), .regfile_read_data_2_out(b_wd),
        .zero_out(b_zero), .mux_rd_rt_out(b_rd),
        .MemToReg_out(b_m2r), .RegWrite_out(b_rw), .MemRead_out(b_mr),
        .MemWrite_out(b_mw), .Branch_out(b_br), .valid_out(b_valid),
        .pc_src_out(b_pc), .fwd_en_out(b_fen), .fwd_reg_out(b_freg), .fwd_data_out(b_fdata),
        .stall_cnt_out(b_stall), .bubble_cnt_out(b_bubble)
    );

    ex_mem_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(SML_CW)) dut_sml (
        .clk(clk), .rst(rst), .hit_in(hit_in), .flush_in(flush_in), .valid_in(valid_in),
        .alu_result_in(alu_in), .adder_result_in(add_in), .regfile_read_data_2_in(wd_in),
        .zero_in(zero_in), .mux_rd_rt_in(rd_in),
        .MemToReg_in(c_in[4]), .RegWrite_in(c_in[3]), .MemRead_in(c_in[2]),
        .MemWrite_in(c_in[1]), .Branch_in(c_in[0]),
        .alu_result_out(s_alu), .adder_result_out(s_add), .regfile_read_data_2_out(s_wd),
        .zero_out(s_zero), .mux_rd_rt_out(s_rd),
        .MemToReg_out(s_m2r), .RegWrite_out(s_rw), .MemRead_out(s_mr),
        .MemWrite_out(s_mw), .Branch_out(s_br), .valid_out(s_valid),
        .pc_src_out(s_pc), .fwd_en_out(s_fen), .fwd_reg_out(s_freg), .fwd_data_out(s_fdata),
        .stall_cnt_out(s_stall), .bubble_cnt_out(s_bubble)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Model: the stage holds one instruction record; counters are plain unbounded tallies.
    bit            m_known = 1'b0;
    logic          m_valid, m_zero;
    logic [DW-1:0] m_alu, m_add, m_wd;
    logic [RW-1:0] m_rd;
    logic [4:0]    m_c;
    int            m_stall, m_bubble;

    always @(negedge clk) begin
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0; m_zero = 1'b0; m_alu = '0; m_add = '0; m_wd = '0;
            m_rd = '0; m_c = '0; m_stall = 0; m_bubble = 0;
        end else if (flush_in) begin
            m_valid = 1'b0;
            m_c = '0;
            m_bubble++;
        end else if (!hit_in) begin
            m_stall++;
        end else begin
            m_valid = valid_in;
            m_alu = alu_in; m_add = add_in; m_wd = wd_in; m_zero = zero_in; m_rd = rd_in;
            m_c = valid_in ? c_in : 5'b0;
            if (!valid_in) m_bubble++;
        end
    end

    function automatic logic [63:0] sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return 64'(v > mx ? mx : v);
    endfunction

    logic exp_pc, exp_fen;
    always_comb begin
        exp_pc  = m_valid & m_c[0] & m_zero;
        exp_fen = m_valid & m_c[3] & ~m_c[2] & (m_rd != '0);
    end

    always @(posedge clk) begin
        if (m_known) begin
            check("alu_result_out", 64'(b_alu), 64'(m_alu));
            check("adder_result_out", 64'(b_add), 64'(m_add));
            check("regfile_read_data_2_out", 64'(b_wd), 64'(m_wd));
            check("zero_out", 64'(b_zero), 64'(m_zero));
            check("mux_rd_rt_out", 64'(b_rd), 64'(m_rd));
            check("ctrl_out", 64'({b_m2r, b_rw, b_mr, b_mw, b_br}), 64'(m_c));
            check("valid_out", 64'(b_valid), 64'(m_valid));
            check("pc_src_out", 64'(b_pc), 64'(exp_pc));
            check("fwd_en_out", 64'(b_fen), 64'(exp_fen));
            check("fwd_reg_out", 64'(b_freg), 64'(m_rd));
            check("fwd_data_out", 64'(b_fdata), 64'(m_alu));
            check("stall_cnt_out", 64'(b_stall), sat(m_stall, BIG_CW));
            check("bubble_cnt_out", 64'(b_bubble), sat(m_bubble, BIG_CW));
            check("small_outputs",
                  64'({s_alu, s_add, s_wd, s_zero, s_rd, s_m2r, s_rw, s_mr, s_mw, s_br,
                       s_valid, s_pc, s_fen}),
                  64'({m_alu, m_add, m_wd, m_zero, m_rd, m_c, m_valid, exp_pc, exp_fen}));
            check("small_fwd", 64'({s_freg, s_fdata}), 64'({m_rd, m_alu}));
            check("small_stall_cnt", 64'(s_stall), sat(m_stall, SML_CW));
            check("small_bubble_cnt", 64'(s_bubble), sat(m_bubble, SML_CW));
        end
    end

    // Inputs change just after the rising edge; the falling edge in between commits them.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic v, input logic [DW-1:0] alu, input logic [RW-1:0] rd,
                        input logic [4:0] c, input logic z);
        rst = 1'b0; flush_in = 1'b0; hit_in = 1'b1;
        valid_in = v; alu_in = alu; rd_in = rd; c_in = c; zero_in = z;
        add_in = DW'($urandom); wd_in = DW'($urandom);
        tick();
    endtask

    task automatic hold();
        rst = 1'b0; flush_in = 1'b0; hit_in = 1'b0;
        valid_in = 1'($urandom); alu_in = DW'($urandom); rd_in = RW'($urandom);
        c_in = 5'($urandom); zero_in = 1'($urandom);
        add_in = DW'($urandom); wd_in = DW'($urandom);
        tick();
    endtask

    initial begin
        rst = 1'b1; hit_in = 1'b1; flush_in = 1'b0; valid_in = 1'b1; zero_in = 1'b0;
        alu_in = 16'hAAAA; add_in = '0; wd_in = '0; rd_in = 3'd5; c_in = 5'b11111;
        @(posedge clk);
        #1;
        tick();
        check("reset alu", 64'(b_alu), 64'h0);
        check("reset valid", 64'(b_valid), 64'h0);
        check("reset fwd_en", 64'(b_fen), 64'h0);
        check("reset pc_src", 64'(b_pc), 64'h0);
        check("reset counters", 64'({b_stall, b_bubble}), 64'h0);

        load(1'b1, 16'h1234, 3'd3, 5'b01000, 1'b0);
        check("load alu", 64'(b_alu), 64'h1234);
        check("load fwd_en", 64'(b_fen), 64'h1);
        check("load fwd_reg", 64'(b_freg), 64'h3);

        load(1'b1, 16'h0042, 3'd1, 5'b00001, 1'b1);
        check("branch taken", 64'(b_pc), 64'h1);
        load(1'b0, 16'h0042, 3'd1, 5'b00001, 1'b1);
        check("bubble pc_src", 64'(b_pc), 64'h0);
        check("bubble Branch_out", 64'(b_br), 64'h0);
        check("bubble count", 64'(b_bubble), 64'h1);

        load(1'b1, 16'hBEEF, 3'd4, 5'b00010, 1'b0);
        for (int i = 0; i < 5; i++) hold();
        check("hold alu", 64'(b_alu), 64'hBEEF);
        check("hold MemWrite", 64'(b_mw), 64'h1);
        check("hold stall count", 64'(b_stall), 64'h5);
        load(1'b1, 16'h5555, 3'd5, 5'b00010, 1'b0);
        check("resume alu", 64'(b_alu), 64'h5555);

        rst = 1'b0; flush_in = 1'b1; hit_in = 1'b0;
        tick();
        check("flush MemWrite", 64'(b_mw), 64'h0);
        check("flush valid", 64'(b_valid), 64'h0);
        check("flush alu", 64'(b_alu), 64'h5555);
        check("flush bubble count", 64'(b_bubble), 64'h2);
        check("flush stall count", 64'(b_stall), 64'h5);

        load(1'b1, 16'h7777, 3'd0, 5'b01000, 1'b0);
        check("rd0 fwd_en", 64'(b_fen), 64'h0);
        load(1'b1, 16'h7777, 3'd2, 5'b01100, 1'b0);
        check("load-use fwd_en", 64'(b_fen), 64'h0);

        rst = 1'b1; flush_in = 1'b1; hit_in = 1'b0;
        tick();
        check("rst+flush+hold outputs",
              64'({b_alu, b_valid, b_m2r, b_rw, b_mr, b_mw, b_br, b_rd}), 64'h0);
        for (int i = 0; i < 9; i++) hold();
        check("small stall saturates", 64'(s_stall), 64'h7);
        check("big stall after 9", 64'(b_stall), 64'h9);
        rst = 1'b1; flush_in = 1'b1; hit_in = 1'b0;
        tick();
        check("second reset counters", 64'({b_stall, b_bubble, s_stall, s_bubble}), 64'h0);
        check("second reset fwd/pc", 64'({b_fen, b_pc}), 64'h0);

        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            flush_in = ($urandom_range(0, 7) == 0);
            hit_in   = ($urandom_range(0, 3) != 0);
            valid_in = ($urandom_range(0, 3) != 0);
            alu_in   = DW'($urandom);
            add_in   = DW'($urandom);
            wd_in    = DW'($urandom);
            rd_in    = RW'($urandom);
            c_in     = 5'($urandom);
            zero_in  = 1'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
